vector_lsu: RTL and testbench

- Memory-side load/store sequencer for the vector register file; sits between the register file's load/store port pair and a narrow word-wide data memory.
- On a load, fetches a full vector from memory as word beats, assembles it, and writes it into the register file through its load port.
- On a store, reads a vector out through the register file's store port and writes it to memory as word beats.
- One command is in flight at a time.

---
 rtl/vector_lsu.sv | 187 ++++++++++++++++++
 tb/tb_vector_lsu.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_lsu.sv
// vector_lsu: moves DATA_W-bit vectors between the RF load/store port pair and a MEM_W-bit word memory.
// Optional macro VLSU_ALIGN_CHECK_EN: misaligned commands end at once with done+error instead of aligning down.
module vector_lsu #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned MEM_W  = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_is_store,
  input  logic [REG_AW-1:0] cmd_reg,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              done,
  output logic              error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  input  logic              mem_ack,
  input  logic [MEM_W-1:0]  mem_rdata,
  output logic              load,
  output logic [REG_AW-1:0] load_addr_reg,
  output logic [DATA_W-1:0] load_data,
  output logic              store,
  output logic [REG_AW-1:0] store_addr_reg,
  input  logic [DATA_W-1:0] store_data
);

  localparam int unsigned BEATS  = DATA_W / MEM_W;
  localparam int unsigned BYTES  = MEM_W / 8;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BUF_IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RF_RD, S_RF_CAP, S_MEM_WR, S_MEM_RD, S_RF_WR, S_DONE
  } state_t;

  state_t              r_state;
  logic                r_ready;
  logic [REG_AW-1:0]   r_reg;
  logic [CNT_W-1:0]    r_idx;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_buf;
  logic [MEM_W-1:0]    r_wdata;
  logic                r_mem_req;
  logic                r_mem_we;
  logic                r_load;
  logic                r_store;
  logic                r_done;

  logic [ADDR_W-1:0]   w_base;
  logic                w_bad;
  logic                w_last;
  logic [CNT_W-1:0]    w_next_idx;
  logic [BUF_IW-1:0]   w_cur_ofs;
  logic [BUF_IW-1:0]   w_next_ofs;

  // Beat addresses always start word-aligned; low offset bits are dropped here.
  assign w_base     = cmd_addr & ~ADDR_W'(BYTES - 1);
  assign w_last     = (r_idx == CNT_W'(BEATS - 1));
  assign w_next_idx = r_idx + CNT_W'(1);
  assign w_cur_ofs  = BUF_IW'(32'(r_idx) * MEM_W);
  assign w_next_ofs = BUF_IW'(32'(w_next_idx) * MEM_W);

`ifdef VLSU_ALIGN_CHECK_EN
  logic r_error;
  assign w_bad = |(cmd_addr & ADDR_W'(BYTES - 1));
  assign error = r_error;
`else
  assign w_bad = 1'b0;
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_reg      <= '0;
      r_idx      <= '0;
      r_mem_addr <= '0;
      r_buf      <= '0;
      r_wdata    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_load     <= 1'b0;
      r_store    <= 1'b0;
      r_done     <= 1'b0;
`ifdef VLSU_ALIGN_CHECK_EN
      r_error    <= 1'b0;
`endif
    end else begin
      r_load  <= 1'b0;
      r_store <= 1'b0;
      r_done  <= 1'b0;
`ifdef VLSU_ALIGN_CHECK_EN
      r_error <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_ready    <= 1'b0;
            r_reg      <= cmd_reg;
            r_idx      <= '0;
            r_mem_addr <= w_base;
            if (w_bad) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
`ifdef VLSU_ALIGN_CHECK_EN
              r_error <= 1'b1;
`endif
            end else if (cmd_is_store) begin
              r_state <= S_RF_RD;
              r_store <= 1'b1;
            end else begin
              r_state   <= S_MEM_RD;
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b0;
            end
          end
        end
        S_RF_RD: r_state <= S_RF_CAP;
        // RF read data arrives one cycle after the strobe.
        S_RF_CAP: begin
          r_buf     <= store_data;
          r_wdata   <= store_data[MEM_W-1:0];
          r_mem_req <= 1'b1;
          r_mem_we  <= 1'b1;
          r_state   <= S_MEM_WR;
        end
        S_MEM_WR: begin
          if (mem_ack) begin
            r_idx      <= w_next_idx;
            r_mem_addr <= r_mem_addr + ADDR_W'(BYTES);
            if (w_last) begin
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_wdata <= r_buf[w_next_ofs +: MEM_W];
            end
          end
        end
        S_MEM_RD: begin
          if (mem_ack) begin
            r_buf[w_cur_ofs +: MEM_W] <= mem_rdata;
            r_idx      <= w_next_idx;
            r_mem_addr <= r_mem_addr + ADDR_W'(BYTES);
            if (w_last) begin
              r_mem_req <= 1'b0;
              r_load    <= 1'b1;
              r_state   <= S_RF_WR;
            end
          end
        end
        S_RF_WR: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready      = r_ready;
  assign done           = r_done;
  assign mem_req        = r_mem_req;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_wdata;
  assign load           = r_load;
  assign load_addr_reg  = r_reg;
  assign load_data      = r_buf;
  assign store          = r_store;
  assign store_addr_reg = r_reg;

endmodule

// File: tb/tb_vector_lsu.sv
// tb_vector_lsu: directed bench with a beat-list model of the expected memory/RF traffic for vector_lsu.
module tb_vector_lsu;
  localparam int unsigned DW = 512;
  localparam int unsigned MW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 3;
  localparam int unsigned NB = DW / MW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_is_store;
  logic [RW-1:0] cmd_reg;
  logic [AW-1:0] cmd_addr;
  logic          done;
  logic          error;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wdata;
  logic          mem_ack;
  logic [MW-1:0] mem_rdata;
  logic          load;
  logic [RW-1:0] load_addr_reg;
  logic [DW-1:0] load_data;
  logic          store;
  logic [RW-1:0] store_addr_reg;
  logic [DW-1:0] store_data;

  vector_lsu dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_store(cmd_is_store),
    .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
    .done(done), .error(error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .load(load), .load_addr_reg(load_addr_reg), .load_data(load_data),
    .store(store), .store_addr_reg(store_addr_reg), .store_data(store_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [MW-1:0] data;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] rf[8];
  logic [DW-1:0] exp_vec;
  logic [DW-1:0] seen_load;
  logic [RW-1:0] exp_reg;
  logic          exp_err;
  logic          last_err;
  int unsigned   wmax;
  int unsigned   wait_left;
  bit            wait_set;
  bit            spur;
  int            n_done, n_load, n_store, n_ack, done_cyc, beat_i;
  int            cyc;
  int            total, bad;
  logic [AW-1:0] addr_log[16];
  logic [AW-1:0] last_addr;
  logic [MW-1:0] last_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] rd_pat(input int k);
    return {32'hA5A5_0000 + 32'(k), 32'(k)};
  endfunction

  // Expected traffic: ascending word beats from the aligned base, wrapping in 32 bits.
  task automatic build(input bit st, input logic [RW-1:0] r, input logic [AW-1:0] a);
    logic [AW-1:0] base;
    exp_q.delete();
    beat_i  = 0;
    exp_reg = r;
    exp_err = 1'b0;
    exp_vec = '0;
`ifdef VLSU_ALIGN_CHECK_EN
    if (a[2:0] != 3'b000) begin
      exp_err = 1'b1;
      return;
    end
`endif
    base = a & ~32'h7;
    for (int k = 0; k < int'(NB); k++) begin
      beat_t b;
      b.addr = base + 32'(k * 8);
      b.we   = st;
      b.data = st ? rf[r][k*MW +: MW] : rd_pat(k);
      exp_q.push_back(b);
      if (!st) exp_vec[k*MW +: MW] = rd_pat(k);
    end
  endtask

  // Memory/RF responder and per-cycle output checker.
  always @(negedge clk) begin
    if (!reset) begin
      mem_ack    = 1'b0;
      mem_rdata  = '0;
      store_data = '0;
      wait_set   = 1'b0;
    end else begin
      if (done) begin
        n_done++;
        done_cyc = cyc;
        last_err = error;
      end
      chk("error", DW'(error), DW'(done & exp_err));
      if (store) begin
        chk("store_addr_reg", DW'(store_addr_reg), DW'(exp_reg));
        store_data = rf[store_addr_reg];
        n_store++;
      end
      if (load) begin
        chk("load_addr_reg", DW'(load_addr_reg), DW'(exp_reg));
        chk("load_data", load_data, exp_vec);
        seen_load = load_data;
        n_load++;
      end
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_mem_req", DW'(mem_req), DW'(1'b0));
          mem_ack = 1'b0;
        end else begin
          chk("mem_addr", DW'(mem_addr), DW'(exp_q[0].addr));
          chk("mem_we", DW'(mem_we), DW'(exp_q[0].we));
          if (exp_q[0].we) chk("mem_wdata", DW'(mem_wdata), DW'(exp_q[0].data));
          if (!wait_set) begin
            wait_left = $urandom_range(wmax, 0);
            wait_set  = 1'b1;
          end
          if (wait_left == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = exp_q[0].data;
            if (beat_i < 16) addr_log[beat_i] = mem_addr;
            beat_i++;
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
            n_ack++;
            wait_set = 1'b0;
            void'(exp_q.pop_front());
          end else begin
            mem_ack   = 1'b0;
            mem_rdata = {$urandom(), $urandom()};
            wait_left--;
          end
        end
      end else begin
        mem_ack   = spur;
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end
    end
  end

  task automatic run_cmd(input bit st, input logic [RW-1:0] r, input logic [AW-1:0] a,
                         input int unsigned wm, input bit sp, input int lat, input int hold);
    int d0, l0, s0, acc, t;
    build(st, r, a);
    wmax = wm;
    spur = sp;
    d0 = n_done; l0 = n_load; s0 = n_store;
    @(negedge clk);
    chk("cmd_ready_idle", DW'(cmd_ready), DW'(1'b1));
    cmd_valid = 1'b1; cmd_is_store = st; cmd_reg = r; cmd_addr = a;
    @(posedge clk);
    #1 acc = cyc;
    chk("cmd_ready_busy", DW'(cmd_ready), DW'(1'b0));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      cmd_reg  = ~r;
      cmd_addr = a + 32'h1000;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (n_done == d0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("done_seen", DW'(n_done != d0), DW'(1'b1));
    if (lat >= 0) chk("latency", DW'(done_cyc - acc + 1), DW'(lat));
    chk("load_count", DW'(n_load - l0), DW'((!st && !exp_err) ? 1 : 0));
    chk("store_count", DW'(n_store - s0), DW'((st && !exp_err) ? 1 : 0));
    chk("beats_left", DW'(exp_q.size()), DW'(0));
    @(negedge clk);
    chk("done_one_cycle", DW'(done), DW'(1'b0));
    chk("cmd_ready_back", DW'(cmd_ready), DW'(1'b1));
  endtask

  initial begin
    int d0, a0, t;
    total = 0; bad = 0;
    n_done = 0; n_load = 0; n_store = 0; n_ack = 0;
    wmax = 0; spur = 1'b0; exp_err = 1'b0; exp_reg = '0; exp_vec = '0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_is_store = 1'b0; cmd_reg = '0; cmd_addr = '0;
    for (int r = 0; r < 8; r++)
      for (int w = 0; w < int'(DW / 32); w++) rf[r][w*32 +: 32] = $urandom();
    for (int k = 0; k < int'(NB); k++) rf[2][k*MW +: MW] = {16{4'(k)}};

    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("rst_cmd_ready", DW'(cmd_ready), DW'(1'b1));
    chk("rst_mem_req", DW'(mem_req), DW'(1'b0));
    chk("rst_load", DW'(load), DW'(1'b0));
    chk("rst_store", DW'(store), DW'(1'b0));
    chk("rst_done", DW'(done), DW'(1'b0));

    // Store, zero-wait, spurious acks outside requests, cmd_valid held while busy.
    run_cmd(1'b1, 3'd2, 32'h100, 0, 1'b1, 11, 3);
    chk("st_first_addr", DW'(addr_log[0]), DW'(32'h100));
    chk("st_last_addr", DW'(last_addr), DW'(32'h138));
    chk("st_last_wdata", DW'(last_wdata), DW'(64'h7777_7777_7777_7777));

    // Load with 0-3 wait states per beat.
    run_cmd(1'b0, 3'd5, 32'h200, 3, 1'b0, -1, 0);
    chk("ld_beat0", DW'(seen_load[63:0]), DW'(64'hA5A5_0000_0000_0000));
    chk("ld_beat1", DW'(seen_load[127:64]), DW'(64'hA5A5_0001_0000_0001));
    chk("ld_beat7", DW'(seen_load[511:448]), DW'(64'hA5A5_0007_0000_0007));

    // Address wrap through 2^32.
    run_cmd(1'b0, 3'd1, 32'hFFFF_FFE0, 0, 1'b1, 10, 0);
    chk("wrap_beat3", DW'(addr_log[3]), DW'(32'hFFFF_FFF8));
    chk("wrap_beat4", DW'(addr_log[4]), DW'(32'h0000_0000));
    chk("wrap_beat7", DW'(last_addr), DW'(32'h0000_0018));

    // Reset in the middle of a store, after beat 3 is acknowledged.
    build(1'b1, 3'd2, 32'h300);
    wmax = 0; spur = 1'b0;
    d0 = n_done; a0 = n_ack;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_is_store = 1'b1; cmd_reg = 3'd2; cmd_addr = 32'h300;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (n_ack - a0 < 4 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("mid_beats_acked", DW'(n_ack - a0 >= 4), DW'(1'b1));
    #1 chk("mid_req_before", DW'(mem_req), DW'(1'b1));
    #1 reset = 1'b0;
    #1;
    chk("mid_mem_req", DW'(mem_req), DW'(1'b0));
    chk("mid_store", DW'(store), DW'(1'b0));
    chk("mid_load", DW'(load), DW'(1'b0));
    chk("mid_cmd_ready", DW'(cmd_ready), DW'(1'b1));
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    chk("mid_no_done", DW'(n_done - d0), DW'(0));
    run_cmd(1'b0, 3'd3, 32'h40, 0, 1'b0, 10, 0);
    chk("post_rst_first", DW'(addr_log[0]), DW'(32'h40));

    // Misaligned base address.
`ifdef VLSU_ALIGN_CHECK_EN
    run_cmd(1'b0, 3'd6, 32'h104, 0, 1'b0, 1, 0);
    chk("align_error", DW'(last_err), DW'(1'b1));
    chk("align_no_beats", DW'(beat_i), DW'(0));
`else
    run_cmd(1'b0, 3'd6, 32'h104, 0, 1'b0, 10, 0);
    chk("align_first", DW'(addr_log[0]), DW'(32'h100));
    chk("align_no_error", DW'(last_err), DW'(1'b0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
